// File: rtl/fs_ctrl_pkg.sv
// Shared definitions for the sample-clock rate controller.
//  - fs_state_e : controller FSM encoding (IDLE / RUN / STOPPING)
//  - FS_CNT_W, FS_DEFAULT_DIV, FS_FRAME_LEN : parameter defaults
//  - fs_active() : true while the divider is counting
package fs_ctrl_pkg;

  localparam int FS_CNT_W       = 16;
  localparam int FS_DEFAULT_DIV = 8;
  localparam int FS_FRAME_LEN   = 69;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } fs_state_e;

  // STOPPING still counts: the current period must finish cleanly.
  function automatic logic fs_active(input fs_state_e st);
    return (st == ST_RUN) || (st == ST_STOPPING);
  endfunction

endpackage

// File: rtl/fs_frame_counter.sv
// Tick-driven modulo-FRAME_LEN counter.
// Ports:
//  clock        in  system clock
//  reset        in  synchronous reset, active-high
//  tick         in  one-cycle sample enable; advances the count
//  clear        in  forces the count back to 0 (controller returning to IDLE)
//  frame_start  out high with the tick that lands on count 0
module fs_frame_counter #(
  parameter int FRAME_LEN = 69
) (
  input  logic clock,
  input  logic reset,
  input  logic tick,
  input  logic clear,
  output logic frame_start
);

  localparam int CW = $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (clear) begin
      count_next = '0;
    end else if (tick) begin
      count_next = (count_reg == LAST) ? '0 : count_reg + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign frame_start = tick && (count_reg == '0);

endmodule

// File: rtl/fs_rate_controller.sv
// Sample-clock divider controller: produces a 50% duty divided clock and a
// one-cycle sample_tick from the system clock, with glitch-free start/stop
// and divisor reloads that only take effect at period boundaries.
// Optional feature macro: FS_FRAME_COUNT_EN (adds the frame counter that
// drives frame_start; without it frame_start is held at 0).
// Ports:
//  clock        in   system clock
//  reset        in   synchronous reset, active-high
//  start        in   pulse: begin generating the sample clock
//  stop         in   pulse: stop at the end of the current full period
//  div_in       in   new half-period terminal count
//  div_valid    in   div_in valid
//  div_ready    out  high when no reload is pending
//  div_err      out  one-cycle pulse: a zero divisor was accepted and clamped to 1
//  clock_out    out  divided sample clock
//  sample_tick  out  one-cycle pulse in the first high cycle of clock_out
//  frame_start  out  one-cycle pulse on tick 0 of each frame
//  running      out  high in RUN/STOPPING
module fs_rate_controller
  import fs_ctrl_pkg::*;
#(
  parameter int CNT_W       = FS_CNT_W,
  parameter int DEFAULT_DIV = FS_DEFAULT_DIV,
  parameter int FRAME_LEN   = FS_FRAME_LEN
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] div_in,
  input  logic             div_valid,
  output logic             div_ready,
  output logic             div_err,
  output logic             clock_out,
  output logic             sample_tick,
  output logic             frame_start,
  output logic             running
);

  fs_state_e        state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             clk_reg, clk_next;
  logic [CNT_W-1:0] div_active_reg, div_active_next;
  logic [CNT_W-1:0] pend_div_reg, pend_div_next;
  logic             pend_valid_reg, pend_valid_next;
  logic             err_reg, err_next;
  logic             tick_reg, tick_next;

  logic active;
  logic wrap;
  logic accept;

  assign active = fs_active(state_reg);
  assign wrap   = (cnt_reg == div_active_reg);
  assign accept = div_valid && !pend_valid_reg;

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    clk_next        = clk_reg;
    div_active_next = div_active_reg;
    pend_div_next   = pend_div_reg;
    pend_valid_next = pend_valid_reg;
    err_next        = 1'b0;
    tick_next       = 1'b0;

    // Capture a new divisor; zero would stall the divider, so clamp it.
    if (accept) begin
      pend_valid_next = 1'b1;
      pend_div_next   = (div_in == '0) ? CNT_W'(1) : div_in;
      err_next        = (div_in == '0);
    end

    case (state_reg)
      ST_IDLE: begin
        cnt_next = '0;
        clk_next = 1'b0;
        // Nothing is being divided, so a pending reload can land right away.
        if (pend_valid_reg) begin
          div_active_next = pend_div_reg;
          pend_valid_next = 1'b0;
        end
        if (start && !stop) begin
          state_next = ST_RUN;
        end
      end

      ST_RUN, ST_STOPPING: begin
        if (state_reg == ST_RUN && stop) begin
          state_next = ST_STOPPING;
        end
        if (wrap) begin
          cnt_next = '0;
          clk_next = !clk_reg;
          if (!clk_reg) begin
            // Rising wrap: the next cycle is the first high cycle.
            tick_next = 1'b1;
          end else begin
            // Falling wrap closes a full period: the only safe point to
            // change the divisor (cnt restarts at 0) or to stop.
            if (pend_valid_reg) begin
              div_active_next = pend_div_reg;
              pend_valid_next = 1'b0;
            end
            if (state_reg == ST_STOPPING) begin
              state_next = ST_IDLE;
            end
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
        clk_next   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= '0;
      clk_reg        <= 1'b0;
      div_active_reg <= CNT_W'(DEFAULT_DIV);
      pend_div_reg   <= '0;
      pend_valid_reg <= 1'b0;
      err_reg        <= 1'b0;
      tick_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      clk_reg        <= clk_next;
      div_active_reg <= div_active_next;
      pend_div_reg   <= pend_div_next;
      pend_valid_reg <= pend_valid_next;
      err_reg        <= err_next;
      tick_reg       <= tick_next;
    end
  end

  assign div_ready   = !pend_valid_reg;
  assign div_err     = err_reg;
  assign clock_out   = clk_reg;
  assign sample_tick = tick_reg;
  assign running     = active;

`ifdef FS_FRAME_COUNT_EN
  logic frame_clear;
  // Frames restart from tick 0 after a controlled stop.
  assign frame_clear = (state_reg == ST_STOPPING) && (state_next == ST_IDLE);

  fs_frame_counter #(
    .FRAME_LEN(FRAME_LEN)
  ) u_frame_counter (
    .clock      (clock),
    .reset      (reset),
    .tick       (tick_reg),
    .clear      (frame_clear),
    .frame_start(frame_start)
  );
`else
  // No frame counter in this build; the term keeps FRAME_LEN referenced
  // and is constant 0.
  assign frame_start = 1'b0 && (FRAME_LEN > 0);
`endif

endmodule

// File: tb/tb_fs_rate_controller.sv
module tb_fs_rate_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        stop;
  logic [15:0] div_in;
  logic        div_valid;
  logic        div_ready;
  logic        div_err;
  logic        clock_out;
  logic        sample_tick;
  logic        frame_start;
  logic        running;

  int n_cmp = 0;
  int n_err = 0;

  always #10 clock = ~clock;

  fs_rate_controller dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .div_in     (div_in),
    .div_valid  (div_valid),
    .div_ready  (div_ready),
    .div_err    (div_err),
    .clock_out  (clock_out),
    .sample_tick(sample_tick),
    .frame_start(frame_start),
    .running    (running)
  );

  typedef struct {
    int          delay;   // cycles into the high phase before the handshake
    logic [15:0] div;
    logic        err;
    int          hi;
    int          per;
  } vec_t;

  vec_t vt [4];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic wait_tick(input string name, output int n);
    n = 0;
    while (!sample_tick && n < 400) begin
      step();
      n++;
    end
    if (!sample_tick) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: no sample_tick within %0d cycles, required one", name, n);
    end
  endtask

  // Called on a tick sample; returns high-phase length and period to the next tick.
  task automatic measure(output int hi, output int per);
    hi = 0;
    while (clock_out && hi < 400) begin
      step();
      hi++;
    end
    per = hi;
    while (!sample_tick && per < 800) begin
      step();
      per++;
    end
  endtask

  task automatic send_div(input logic [15:0] v);
    div_in    = v;
    div_valid = 1'b1;
    step();
    div_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_clock_out"}, clock_out, 0);
    check({tag, "_sample_tick"}, sample_tick, 0);
    check({tag, "_running"}, running, 0);
    check({tag, "_div_ready"}, div_ready, 1);
    check({tag, "_div_err"}, div_err, 0);
    check({tag, "_frame_start"}, frame_start, 0);
  endtask

  initial begin
    int n, hi, per, ticks, highs, k;
    bit prev_running;
    logic exp_fs;

    vt[0] = '{4, 16'd3, 1'b0, 4, 8};
    vt[1] = '{0, 16'd0, 1'b1, 2, 4};
    vt[2] = '{0, 16'd5, 1'b0, 6, 12};
    vt[3] = '{0, 16'd8, 1'b0, 9, 18};

    reset = 1'b1; start = 1'b0; stop = 1'b0; div_in = '0; div_valid = 1'b0;
    repeat (3) step();
    check_reset_outputs("reset");
    reset = 1'b0;
    step();

    // Default divisor: 9 cycles to first tick, 9 high / 18 period.
    start = 1'b1; step(); start = 1'b0;
    check("run_entered", running, 1);
    check("run_clock_low", clock_out, 0);
    wait_tick("first_tick", n);
    check("first_tick_latency", n, 9);
    check("tick_with_clock_high", clock_out, 1);
    measure(hi, per);
    check("default_high", hi, 9);
    check("default_period", per, 18);
    measure(hi, per);
    check("default_period_again", per, 18);

    // Reload table: handshake in the high phase, check the following period.
    for (int i = 0; i < 4; i++) begin
      wait_tick("reload_align", n);
      repeat (vt[i].delay) step();
      send_div(vt[i].div);
      check($sformatf("reload%0d_ready_low", i), div_ready, 0);
      check($sformatf("reload%0d_err", i), div_err, vt[i].err);
      step();
      check($sformatf("reload%0d_err_pulse_end", i), div_err, 0);
      wait_tick("reload_period", n);
      check($sformatf("reload%0d_ready_back", i), div_ready, 1);
      measure(hi, per);
      check($sformatf("reload%0d_high", i), hi, vt[i].hi);
      check($sformatf("reload%0d_period", i), per, vt[i].per);
    end

    // Stop a few cycles into the high phase: finish the period, then idle.
    repeat (3) step();
    stop = 1'b1; step(); stop = 1'b0;
    check("stopping_running", running, 1);
    n = 0;
    prev_running = running;
    while (clock_out && n < 50) begin
      prev_running = running;
      step();
      n++;
    end
    check("stop_fall_at_wrap", n, 5);
    check("stop_running_before_fall", prev_running, 1);
    check("stop_running_at_fall", running, 0);
    ticks = 0; highs = 0;
    repeat (60) begin
      step();
      ticks += int'(sample_tick);
      highs += int'(clock_out);
    end
    check("stopped_no_ticks", ticks, 0);
    check("stopped_clock_low", highs, 0);

    // start and stop together in IDLE: stop wins.
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    check("start_stop_idle", running, 0);
    ticks = 0;
    repeat (30) begin
      step();
      ticks += int'(sample_tick);
    end
    check("start_stop_no_ticks", ticks, 0);

    // Reload while idle applies on the next cycle.
    send_div(16'd4);
    check("idle_reload_ready_low", div_ready, 0);
    step();
    check("idle_reload_ready_back", div_ready, 1);
    start = 1'b1; step(); start = 1'b0;
    wait_tick("idle_reload_tick", n);
    check("idle_reload_latency", n, 5);
    measure(hi, per);
    check("idle_reload_period", per, 10);

    // Reset mid-high with a reload pending.
    send_div(16'd2);
    check("pending_before_reset", div_ready, 0);
    step();
    reset = 1'b1; step();
    check_reset_outputs("midrun_reset");
    reset = 1'b0;
    step();
    start = 1'b1; step(); start = 1'b0;
    wait_tick("restart_tick", n);
    check("restart_latency", n, 9);
    measure(hi, per);
    check("restart_period", per, 18);

    // Frame pulses over 140 ticks with the shortest period.
    reset = 1'b1; step(); reset = 1'b0;
    send_div(16'd1);
    step();
    start = 1'b1; step(); start = 1'b0;
    k = -1;
    n = 0;
    while (k < 139 && n < 2000) begin
      if (sample_tick) k++;
`ifdef FS_FRAME_COUNT_EN
      exp_fs = sample_tick && (k % 69 == 0);
`else
      exp_fs = 1'b0;
`endif
      if (sample_tick || frame_start) begin
        check($sformatf("frame_start_tick%0d", k), frame_start, exp_fs);
      end
      step();
      n++;
    end
    check("frame_ticks_seen", k, 139);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
